// File: rtl/fifo_top.sv
// Single-clock FIFO with registered read data and full/empty flags derived from wrap-bit pointers.
// Define FIFO_STATUS_EN to add the occupancy count and sticky overflow/underflow outputs.
module fifo_top #(
  parameter int unsigned dataWidth = 8,
  parameter int unsigned addrWidth = 3
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic [dataWidth-1:0] dataIn,
  input  logic                 writeEnableIn,
  input  logic                 readEnableIn,
  output logic [dataWidth-1:0] dataOut,
  output logic                 fifoFullOut,
  output logic                 fifoEmptyOut
`ifdef FIFO_STATUS_EN
  ,
  output logic [addrWidth:0]   countOut,
  output logic                 overflowOut,
  output logic                 underflowOut
`endif
);

  localparam int unsigned Depth = 1 << addrWidth;

  typedef logic [addrWidth:0]   ptr_t;
  typedef logic [dataWidth-1:0] word_t;

  word_t mem_q [Depth];
  ptr_t  wptr_q, wptr_d;
  ptr_t  rptr_q, rptr_d;
  word_t rdata_q, rdata_d;
  logic  wr_accept;
  logic  rd_accept;

  // Equal index bits with differing wrap bits means the writer is a full lap ahead.
  assign fifoEmptyOut = (wptr_q == rptr_q);
  assign fifoFullOut  = (wptr_q[addrWidth-1:0] == rptr_q[addrWidth-1:0]) &&
                        (wptr_q[addrWidth] != rptr_q[addrWidth]);

  assign wr_accept = writeEnableIn & ~fifoFullOut;
  assign rd_accept = readEnableIn & ~fifoEmptyOut;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (wr_accept) begin
      wptr_d = wptr_q + ptr_t'(1);
    end
    if (rd_accept) begin
      rptr_d  = rptr_q + ptr_t'(1);
      rdata_d = mem_q[rptr_q[addrWidth-1:0]];
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; pointer reset alone discards the contents.
  always_ff @(posedge clkIn) begin
    if (rstIn && wr_accept) begin
      mem_q[wptr_q[addrWidth-1:0]] <= dataIn;
    end
  end

  assign dataOut = rdata_q;

`ifdef FIFO_STATUS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (writeEnableIn & fifoFullOut);
    underflow_d = underflow_q | (readEnableIn & fifoEmptyOut);
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign countOut     = wptr_q - rptr_q;
  assign overflowOut  = overflow_q;
  assign underflowOut = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_top.sv
// Directed bench for fifo_top: table-driven fill/drain/boundary vectors plus streaming,
// wrap-around and mid-operation reset sequences.
module tb_fifo_top;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       we;
  logic       re;
  logic [7:0] dout;
  logic       full;
  logic       empty;
`ifdef FIFO_STATUS_EN
  logic [3:0] cnt;
  logic       ovf;
  logic       unf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_top #(
    .dataWidth(8),
    .addrWidth(3)
  ) dut (
    .clkIn        (clk),
    .rstIn        (rst_n),
    .dataIn       (din),
    .writeEnableIn(we),
    .readEnableIn (re),
    .dataOut      (dout),
    .fifoFullOut  (full),
    .fifoEmptyOut (empty)
`ifdef FIFO_STATUS_EN
    ,
    .countOut     (cnt),
    .overflowOut  (ovf),
    .underflowOut (unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic w, input logic r, input logic [7:0] d,
                              input logic [7:0] q, input logic f, input logic e,
                              input logic [3:0] c);
    vec_t v;
    v.we = w; v.re = r; v.din = d; v.dout = q; v.full = f; v.empty = e; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [3:0] exp);
`ifdef FIFO_STATUS_EN
    check(name, 32'(cnt), 32'(exp));
`else
    if (exp > 4'd8) $display("note: count %0d out of range in %s", exp, name);
`endif
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    we = w; re = r; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_empty", 32'(empty), 32'h1);
    check("reset_full", 32'(full), 32'h0);
    check_cnt("reset_count", 4'd0);
`ifdef FIFO_STATUS_EN
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_unf", 32'(unf), 32'h0);
`endif
    rst_n = 1'b1;

    // Fill, overflow, drain, underflow, then both boundary simultaneous cases
    for (int i = 0; i < 8; i++) add(1, 0, 8'(8'h10 + i), 8'h00, i == 7, 0, 4'(i + 1));
    add(1, 0, 8'hFF, 8'h00, 1, 0, 4'd8);
    for (int i = 0; i < 8; i++) add(0, 1, 8'h00, 8'(8'h10 + i), 0, i == 7, 4'(7 - i));
    add(0, 1, 8'h00, 8'h17, 0, 1, 4'd0);
    add(1, 1, 8'h55, 8'h17, 0, 0, 4'd1);
    for (int i = 0; i < 7; i++) add(1, 0, 8'(8'h60 + i), 8'h17, i == 6, 0, 4'(i + 2));
    add(1, 1, 8'hAA, 8'h55, 0, 0, 4'd7);
    for (int i = 0; i < 7; i++) add(0, 1, 8'h00, 8'(8'h60 + i), 0, i == 6, 4'(6 - i));

    foreach (vecs[k]) begin
      cycle(vecs[k].we, vecs[k].re, vecs[k].din);
      check($sformatf("vec%0d_dout", k), 32'(dout), 32'(vecs[k].dout));
      check($sformatf("vec%0d_full", k), 32'(full), 32'(vecs[k].full));
      check($sformatf("vec%0d_empty", k), 32'(empty), 32'(vecs[k].empty));
      check_cnt($sformatf("vec%0d_count", k), vecs[k].cnt);
    end
`ifdef FIFO_STATUS_EN
    check("sticky_ovf", 32'(ovf), 32'h1);
    check("sticky_unf", 32'(unf), 32'h1);
`endif

    // Streaming: read held high, a write every other cycle
    for (int k = 0; k < 10; k++) begin
      cycle(1, 1, 8'(k));
      check($sformatf("stream%0d_wr_empty", k), 32'(empty), 32'h0);
      check($sformatf("stream%0d_wr_full", k), 32'(full), 32'h0);
      cycle(0, 1, 8'h00);
      check($sformatf("stream%0d_dout", k), 32'(dout), 32'(k));
      check($sformatf("stream%0d_empty", k), 32'(empty), 32'h1);
      check($sformatf("stream%0d_full", k), 32'(full), 32'h0);
    end

    // Wrap-around: 20 values through with 4 in flight, pointers cross the wrap bit
    for (int k = 0; k < 4; k++) cycle(1, 0, 8'(k));
    check_cnt("wrap_prefill_count", 4'd4);
    for (int k = 4; k < 20; k++) begin
      cycle(1, 1, 8'(k));
      check($sformatf("wrap%0d_dout", k), 32'(dout), 32'(k - 4));
      check($sformatf("wrap%0d_empty", k), 32'(empty), 32'h0);
      check($sformatf("wrap%0d_full", k), 32'(full), 32'h0);
      check_cnt($sformatf("wrap%0d_count", k), 4'd4);
    end
    for (int k = 16; k < 20; k++) begin
      cycle(0, 1, 8'h00);
      check($sformatf("wrapdrain%0d_dout", k), 32'(dout), 32'(k));
      check($sformatf("wrapdrain%0d_empty", k), 32'(empty), 32'(k == 19));
    end

    // Reset mid-operation with 5 words stored; reset beats concurrent read/write
    for (int k = 0; k < 5; k++) cycle(1, 0, 8'(8'h30 + k));
    check("midrst_pre_empty", 32'(empty), 32'h0);
    rst_n = 1'b0;
    cycle(1, 1, 8'hEE);
    rst_n = 1'b1;
    check("midrst_empty", 32'(empty), 32'h1);
    check("midrst_full", 32'(full), 32'h0);
    check("midrst_dout", 32'(dout), 32'h0);
    check_cnt("midrst_count", 4'd0);
    cycle(1, 0, 8'h99);
    check("postrst_wr_empty", 32'(empty), 32'h0);
    cycle(0, 1, 8'h00);
    check("postrst_dout", 32'(dout), 32'h99);
    check("postrst_empty", 32'(empty), 32'h1);
    cycle(0, 1, 8'h00);
    check("postrst_hold_dout", 32'(dout), 32'h99);
    check("postrst_hold_empty", 32'(empty), 32'h1);

    cycle(0, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
